// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: parses "!<M|G><digits>\r" frames from the UART receive stream, delivers the
// decimal value to the MGU or GNU over valid/ready, and answers each frame with ACK or NAK.
// Inter-byte silence in TGT/DIGIT longer than TIMEOUT_CLKS aborts the frame with a NAK.

module uart_cmd_sched #(
    parameter int unsigned TIMEOUT_CLKS = 17360,
    parameter int unsigned MAX_DIGITS   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic [15:0] o_mgu_cmd,
    output logic        o_mgu_vld,
    input  logic        i_mgu_rdy,
    output logic [15:0] o_gnu_cmd,
    output logic        o_gnu_vld,
    input  logic        i_gnu_rdy,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_active,
    output logic        o_busy,
    output logic [7:0]  o_err_cnt
);

    localparam int unsigned CntW  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int unsigned DcntW = $clog2(MAX_DIGITS + 1);

    localparam logic [CntW-1:0]  TimeoutLast = CntW'(TIMEOUT_CLKS - 1);
    localparam logic [DcntW-1:0] DigitMax    = DcntW'(MAX_DIGITS);

    localparam logic [7:0] ChBang = 8'h21;
    localparam logic [7:0] ChM    = 8'h4D;
    localparam logic [7:0] ChG    = 8'h47;
    localparam logic [7:0] ChCr   = 8'h0D;
    localparam logic [7:0] ChAck  = 8'h06;
    localparam logic [7:0] ChNak  = 8'h15;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StTgt   = 3'd1;
    localparam logic [2:0] StDigit = 3'd2;
    localparam logic [2:0] StIssue = 3'd3;
    localparam logic [2:0] StAck   = 3'd4;
    localparam logic [2:0] StNak   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [16:0]      acc_q, acc_d;
    logic [DcntW-1:0] dcnt_q, dcnt_d;
    logic             ovf_q, ovf_d;
    logic             tgt_q, tgt_d;      // 1 = GNU, 0 = MGU
    logic [CntW-1:0]  tmo_q;
    logic [15:0]      mgu_cmd_q, gnu_cmd_q;
    logic             mgu_vld_q, gnu_vld_q;
    logic [7:0]       tx_byte_q;
    logic [7:0]       err_cnt_q;

    logic        is_digit;
    logic [3:0]  digit;
    logic [20:0] acc_mac;
    logic        timed_state;
    logic        tmo_hit;
    logic        sel_rdy;
    logic        go_issue, go_ack, go_nak;

    assign is_digit    = (i_rx_byte >= 8'h30) && (i_rx_byte <= 8'h39);
    assign digit       = i_rx_byte[3:0];
    assign acc_mac     = ({4'b0, acc_q} * 21'd10) + {17'b0, digit};
    assign timed_state = (state_q == StTgt) || (state_q == StDigit);
    // A byte in the expiry cycle wins over the timeout.
    assign tmo_hit     = timed_state && !i_rx_dv && (tmo_q == TimeoutLast);
    assign sel_rdy     = tgt_q ? i_gnu_rdy : i_mgu_rdy;

    // Next-state and frame-parsing decode.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        dcnt_d   = dcnt_q;
        ovf_d    = ovf_q;
        tgt_d    = tgt_q;
        go_issue = 1'b0;
        go_ack   = 1'b0;
        go_nak   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_rx_dv && i_rx_byte == ChBang) state_d = StTgt;
            end
            StTgt: begin
                if (i_rx_dv) begin
                    if (i_rx_byte == ChM || i_rx_byte == ChG) begin
                        tgt_d   = (i_rx_byte == ChG);
                        acc_d   = '0;
                        dcnt_d  = '0;
                        ovf_d   = 1'b0;
                        state_d = StDigit;
                    end else if (i_rx_byte != ChBang) begin
                        go_nak = 1'b1;
                    end
                end else if (tmo_hit) begin
                    go_nak = 1'b1;
                end
            end
            StDigit: begin
                if (i_rx_dv) begin
                    if (is_digit) begin
                        if (dcnt_q < DigitMax) begin
                            acc_d  = acc_mac[16:0];
                            dcnt_d = dcnt_q + 1'b1;
                            ovf_d  = ovf_q || (acc_mac > 21'd65535);
                        end else begin
                            go_nak = 1'b1;
                        end
                    end else if (i_rx_byte == ChCr) begin
                        if (dcnt_q != '0 && !ovf_q) begin
                            go_issue = 1'b1;
                            state_d  = StIssue;
                        end else begin
                            go_nak = 1'b1;
                        end
                    end else if (i_rx_byte == ChBang) begin
                        // Silent restart of the frame.
                        state_d = StTgt;
                    end else begin
                        go_nak = 1'b1;
                    end
                end else if (tmo_hit) begin
                    go_nak = 1'b1;
                end
            end
            StIssue: begin
                if (sel_rdy) begin
                    go_ack  = 1'b1;
                    state_d = StAck;
                end
            end
            StAck, StNak: begin
                if (!i_tx_active) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (go_nak) state_d = StNak;
    end

    // State, accumulator, timeout counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            dcnt_q    <= '0;
            ovf_q     <= 1'b0;
            tgt_q     <= 1'b0;
            tmo_q     <= '0;
            mgu_cmd_q <= '0;
            gnu_cmd_q <= '0;
            mgu_vld_q <= 1'b0;
            gnu_vld_q <= 1'b0;
            tx_byte_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            tgt_q   <= tgt_d;
            // Counter is idle at zero outside TGT/DIGIT, so entry always starts from zero.
            if (!timed_state || i_rx_dv || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (go_issue) begin
                if (tgt_q) begin
                    gnu_cmd_q <= acc_q[15:0];
                    gnu_vld_q <= 1'b1;
                end else begin
                    mgu_cmd_q <= acc_q[15:0];
                    mgu_vld_q <= 1'b1;
                end
            end
            if (go_ack) begin
                mgu_vld_q <= 1'b0;
                gnu_vld_q <= 1'b0;
                tx_byte_q <= ChAck;
            end
            if (go_nak) begin
                tx_byte_q <= ChNak;
                if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign o_mgu_cmd = mgu_cmd_q;
    assign o_mgu_vld = mgu_vld_q;
    assign o_gnu_cmd = gnu_cmd_q;
    assign o_gnu_vld = gnu_vld_q;
    assign o_tx_byte = tx_byte_q;
    assign o_err_cnt = err_cnt_q;
    assign o_busy    = (state_q != StIdle);
    // Strobe in the first ACK/NAK cycle the transmitter is free; the state leaves on that edge.
    assign o_tx_dv   = ((state_q == StAck) || (state_q == StNak)) && !i_tx_active;

endmodule

// File: doc/uart_cmd_sched.md
Name: uart_cmd_sched

Overview:
Command sequencer between the UART receiver byte stream and the two command consumers, MGU and GNU.
- Parses ASCII frames of the form "!", target, 1..MAX_DIGITS decimal digits, CR.
- Converts the digits to a 16-bit binary value and delivers it to the addressed target over a valid/ready handshake.
- Answers every frame with an ACK or NAK byte on the UART transmitter interface.
- Replaces the fixed 4-byte shift-register decode with a checked, timed-out, back-pressured flow.

Parameters:
TIMEOUT_CLKS, 17360, inter-byte timeout in clk cycles (4 byte times at 50 MHz, 115200 baud).
MAX_DIGITS, 5, maximum decimal digits accepted per frame.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
i_rx_dv  input  1  one-cycle strobe: i_rx_byte is valid
i_rx_byte  input  8  received byte
o_mgu_cmd  output  16  MGU command value
o_mgu_vld  output  1  MGU command valid
i_mgu_rdy  input  1  MGU accepts command
o_gnu_cmd  output  16  GNU command value
o_gnu_vld  output  1  GNU command valid
i_gnu_rdy  input  1  GNU accepts command
o_tx_dv  output  1  one-cycle strobe: send o_tx_byte
o_tx_byte  output  8  response byte, 0x06 ACK or 0x15 NAK
i_tx_active  input  1  UART transmitter busy
o_busy  output  1  high in every state except IDLE
o_err_cnt  output  8  NAK count, saturates at 255

Behaviour:
Clocking and reset:
- One clock, clk. Reset is asynchronous and active-high.
- On rst: state IDLE, accumulator 0, digit count 0, timeout counter 0.
- Output reset values: all outputs 0, including both cmd buses, both vld, o_tx_dv, o_tx_byte, o_err_cnt.
- Reset mid-frame or mid-handshake aborts the operation; a pending vld drops immediately and no response byte is sent.

Bytes:
- A byte is consumed only in a cycle with i_rx_dv=1.
- Digit bytes are 0x30..0x39; their value is byte-0x30.

FSM states: IDLE, TGT, DIGIT, ISSUE, ACK, NAK.
IDLE:
- 0x21 ('!') -> TGT.
- Any other byte is ignored.
TGT:
- 0x4D ('M') or 0x47 ('G') -> latch target, clear accumulator and digit count, go to DIGIT.
- 0x21 -> stay in TGT (resync).
- Any other byte -> NAK.
DIGIT:
- Digit byte with count<MAX_DIGITS -> acc = acc*10 + digit, count+1.
  - acc is 17 bits; set a sticky overflow flag if the result exceeds 65535.
- Digit byte with count==MAX_DIGITS -> NAK.
- 0x0D with count>=1 and no overflow -> ISSUE.
- 0x0D with count==0 or overflow -> NAK.
- 0x21 -> TGT. This is a silent restart: no NAK and no error count.
- Any other byte -> NAK.
Timeout:
- Active in TGT and DIGIT only.
- The counter clears on entry to either state and on every i_rx_dv.
- When the counter reaches TIMEOUT_CLKS-1 with no byte -> NAK.
- If i_rx_dv arrives in the same cycle the counter reaches TIMEOUT_CLKS-1, the byte wins and the counter clears.
ISSUE:
- The cycle after CR is consumed, the target cmd register loads acc[15:0] and its vld goes high.
  - Latency from the CR i_rx_dv edge to vld high is 1 clk.
- vld and cmd hold stable until rdy=1 at a rising edge.
  - The next cycle vld=0 and state is ACK.
- rdy already high when vld rises gives a 1-cycle vld pulse.
- The non-addressed target's vld stays 0 and its cmd is unchanged.
- cmd registers hold their last value indefinitely.
- No timeout applies in ISSUE.
ACK / NAK:
- In the first cycle with i_tx_active=0, o_tx_dv=1 for exactly 1 cycle, with o_tx_byte = 0x06 (ACK) or 0x15 (NAK).
- The next state after that cycle is IDLE.
- o_tx_byte holds its value after the strobe.
- On entry to NAK, o_err_cnt increments by 1; it does not increment past 255.
Busy:
- Bytes arriving in ISSUE, ACK or NAK are dropped without response.
- o_busy indicates this window.

Test Plan:
- "!M1234\r" with i_mgu_rdy=1 -> o_mgu_vld pulses 1 cycle with o_mgu_cmd=0x04D2; then o_tx_dv with 0x06; o_gnu_vld stays 0.
- "!G65535\r" with i_gnu_rdy held 0 for 20 cycles, then 1 -> o_gnu_vld high for 21 cycles with o_gnu_cmd=0xFFFF; ACK follows the handshake.
- "!M65536\r", then "!G123456", then "!X" -> three NAKs (0x15), o_err_cnt=3, neither vld asserts.
- "!M12", then silence for TIMEOUT_CLKS -> NAK, o_err_cnt=1.
- A byte arriving in the same cycle the counter reaches TIMEOUT_CLKS-1 -> no NAK.
- "!M1!G7\r" -> no NAK; o_gnu_cmd=7 with ACK; o_mgu_cmd unchanged.
- i_tx_active held 1 during the response -> o_tx_dv is deferred until i_tx_active=0.
- rst asserted while o_mgu_vld=1 -> vld=0 immediately; no tx strobe; state IDLE.
